// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared constants and bank-state type for the JPEG coefficient buffer
package jpeg_pkg;
  localparam int JPEG_NUM_COEF = 64;
  localparam int JPEG_COEF_W = 16;
  typedef enum logic [1:0] {BANK_FREE, BANK_FILL, BANK_FULL, BANK_DRAIN} bank_st_e;
endpackage

// File: rtl/jpeg_zigzag_rom.sv
// jpeg_zigzag_rom: combinational zig-zag position to natural (raster) index map
// Ports: zz = zig-zag position 0..63, nat = raster index of that coefficient.
module jpeg_zigzag_rom
  import jpeg_pkg::*;
(
  input  logic [5:0] zz,
  output logic [5:0] nat
);
  localparam logic [5:0] MAP [JPEG_NUM_COEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  assign nat = MAP[zz];
endmodule

// File: rtl/jpeg_coef_bank_ctrl.sv
// jpeg_coef_bank_ctrl: ping-pong de-zig-zag coefficient buffer between decoder and IDCT
// Ports: inport_* = sparse zig-zag coefficient pushes closed by eob (id sampled on eob),
// inport_blk_space_o = current fill bank can take a block; outport_* = dense raster-order
// 64-beat blocks with valid/accept handshake, last on index 63; img_start_i flushes all.
module jpeg_coef_bank_ctrl
  import jpeg_pkg::*;
#(
  parameter int DATA_W = JPEG_COEF_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              img_start_i,
  input  logic              inport_valid_i,
  input  logic [DATA_W-1:0] inport_data_i,
  input  logic [5:0]        inport_idx_i,
  input  logic [31:0]       inport_id_i,
  input  logic              inport_eob_i,
  output logic              inport_blk_space_o,
  output logic              outport_valid_o,
  output logic [DATA_W-1:0] outport_data_o,
  output logic [5:0]        outport_idx_o,
  output logic [31:0]       outport_id_o,
  output logic              outport_last_o,
  input  logic              outport_accept_i
);
  logic [DATA_W-1:0] mem [2][JPEG_NUM_COEF];
  bank_st_e st_q [2];
  logic [JPEG_NUM_COEF-1:0] mask_q [2];
  logic [31:0] id_q [2];
  logic wr_bank_q, rd_bank_q, rd_run_q, rd_mask_q;
  logic [5:0] rd_idx_q, nat;
  logic [DATA_W-1:0] rd_word_q;
  logic wr_open, wr_en, issue, done;
  jpeg_zigzag_rom u_rom (.zz(inport_idx_i), .nat(nat));
  assign wr_open = st_q[wr_bank_q] == BANK_FREE || st_q[wr_bank_q] == BANK_FILL;
  assign wr_en = inport_valid_i && wr_open && !img_start_i;
  // rd_run_q covers beats 1..63 of a drain; beat 0 is launched straight off a FULL bank
  assign issue = (!outport_valid_o || outport_accept_i) && !img_start_i &&
                 (rd_run_q || st_q[rd_bank_q] == BANK_FULL);
  assign done = outport_valid_o && outport_last_o && outport_accept_i;
  assign inport_blk_space_o = wr_open;
  // stale RAM contents from earlier blocks are hidden by the registered mask bit
  assign outport_data_o = rd_mask_q ? rd_word_q : '0;
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_bank_q][nat] <= inport_data_i;
    if (issue) rd_word_q <= mem[rd_bank_q][rd_idx_q];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q[0] <= BANK_FREE;
      st_q[1] <= BANK_FREE;
      mask_q[0] <= '0;
      mask_q[1] <= '0;
      id_q[0] <= '0;
      id_q[1] <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_run_q <= 1'b0;
      rd_idx_q <= '0;
      rd_mask_q <= 1'b0;
      outport_valid_o <= 1'b0;
      outport_idx_o <= '0;
      outport_id_o <= '0;
      outport_last_o <= 1'b0;
    end else if (img_start_i) begin
      st_q[0] <= BANK_FREE;
      st_q[1] <= BANK_FREE;
      mask_q[0] <= '0;
      mask_q[1] <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_run_q <= 1'b0;
      rd_idx_q <= '0;
      rd_mask_q <= 1'b0;
      outport_valid_o <= 1'b0;
      outport_last_o <= 1'b0;
    end else begin
      if (wr_en) begin
        mask_q[wr_bank_q][nat] <= 1'b1;
        if (st_q[wr_bank_q] == BANK_FREE) st_q[wr_bank_q] <= BANK_FILL;
      end
      if (inport_eob_i && wr_open) begin
        id_q[wr_bank_q] <= inport_id_i;
        st_q[wr_bank_q] <= BANK_FULL;
        wr_bank_q <= ~wr_bank_q;
      end
      if (issue) begin
        if (st_q[rd_bank_q] == BANK_FULL) st_q[rd_bank_q] <= BANK_DRAIN;
        rd_idx_q <= rd_idx_q + 6'd1;
        rd_run_q <= rd_idx_q != 6'd63;
        rd_mask_q <= mask_q[rd_bank_q][rd_idx_q];
        outport_valid_o <= 1'b1;
        outport_idx_o <= rd_idx_q;
        outport_id_o <= id_q[rd_bank_q];
        outport_last_o <= &rd_idx_q;
      end else if (outport_accept_i) begin
        outport_valid_o <= 1'b0;
        outport_last_o <= 1'b0;
      end
      // the drained bank is always the other one from any bank the write side touches
      if (done) begin
        st_q[rd_bank_q] <= BANK_FREE;
        mask_q[rd_bank_q] <= '0;
        rd_bank_q <= ~rd_bank_q;
      end
    end
  end
endmodule

// File: tb/tb_jpeg_coef_bank_ctrl.sv
// tb_jpeg_coef_bank_ctrl: directed self-checking bench for jpeg_coef_bank_ctrl
module tb_jpeg_coef_bank_ctrl;
  logic clk = 0, rst_n = 0, img_start = 0;
  logic in_valid = 0, in_eob = 0, accept = 0;
  logic [15:0] in_data = '0;
  logic [5:0] in_idx = '0;
  logic [31:0] in_id = '0;
  logic blk_space, out_valid, out_last;
  logic [15:0] out_data;
  logic [5:0] out_idx;
  logic [31:0] out_id;
  logic [15:0] exp_blk [64];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  jpeg_coef_bank_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .img_start_i(img_start),
    .inport_valid_i(in_valid), .inport_data_i(in_data), .inport_idx_i(in_idx),
    .inport_id_i(in_id), .inport_eob_i(in_eob), .inport_blk_space_o(blk_space),
    .outport_valid_o(out_valid), .outport_data_o(out_data), .outport_idx_o(out_idx),
    .outport_id_o(out_id), .outport_last_o(out_last), .outport_accept_i(accept)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_exp();
    for (int i = 0; i < 64; i++) exp_blk[i] = '0;
  endtask
  task automatic push(input logic [5:0] zz, input logic [15:0] d);
    in_valid = 1; in_idx = zz; in_data = d;
    tick();
    in_valid = 0;
  endtask
  task automatic eob(input logic [31:0] id);
    in_eob = 1; in_id = id;
    tick();
    in_eob = 0;
  endtask
  // consumes one full block; returns one cycle after the final accept
  task automatic drain(input logic [31:0] id, input bit rnd);
    int n = 0, cyc = 0;
    logic pv = 0;
    logic [15:0] pd = '0;
    logic [5:0] pi = '0;
    while (n < 64 && cyc < 2000) begin
      accept = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(pd));
        check("hold_idx", 32'(out_idx), 32'(pi));
      end
      if (out_valid) begin
        check("beat_idx", 32'(out_idx), n);
        check("beat_data", 32'(out_data), 32'(exp_blk[n]));
        check("beat_last", 32'(out_last), 32'(n == 63));
        check("beat_id", out_id, id);
      end
      pv = out_valid && !accept;
      pd = out_data;
      pi = out_idx;
      if (out_valid && accept) n++;
      tick();
      cyc++;
    end
    accept = 0;
    check("beat_count", n, 64);
  endtask
  initial begin
    int c;
    #12;
    check("rst_space", 32'(blk_space), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_id", out_id, 32'd0);
    @(negedge clk);
    rst_n = 1;
    tick();
    clr_exp();
    exp_blk[0] = 16'd100;
    exp_blk[8] = 16'hFFFB;
    push(6'd0, 16'd100);
    push(6'd2, 16'hFFFB);
    eob(32'd1);
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    check("lat_n2_idx", 32'(out_idx), 32'd0);
    drain(32'd1, 0);
    clr_exp();
    exp_blk[2] = 16'd9;
    push(6'd5, 16'd7);
    push(6'd5, 16'd9);
    eob(32'd2);
    drain(32'd2, 0);
    clr_exp();
    eob(32'd3);
    drain(32'd3, 0);
    exp_blk[0] = 16'd1;
    push(6'd0, 16'd1);
    eob(32'd4);
    drain(32'd4, 0);
    clr_exp();
    eob(32'd10);
    check("b2b_space1", 32'(blk_space), 32'd1);
    eob(32'd11);
    check("b2b_space2", 32'(blk_space), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b2b_stall_space", 32'(blk_space), 32'd0);
      check("b2b_stall_idx", 32'(out_idx), 32'd0);
    end
    drain(32'd10, 0);
    check("b2b_m1_space", 32'(blk_space), 32'd1);
    check("b2b_m1_bubble", 32'(out_valid), 32'd0);
    tick();
    check("b2b_m2_valid", 32'(out_valid), 32'd1);
    check("b2b_m2_idx", 32'(out_idx), 32'd0);
    check("b2b_m2_id", out_id, 32'd11);
    drain(32'd11, 0);
    eob(32'd12);
    drain(32'd12, 0);
    clr_exp();
    exp_blk[1] = 16'd3;
    exp_blk[63] = 16'hFFFF;
    exp_blk[32] = 16'h1234;
    push(6'd1, 16'd3);
    push(6'd63, 16'hFFFF);
    push(6'd10, 16'h1234);
    eob(32'd20);
    drain(32'd20, 1);
    push(6'd0, 16'd5);
    eob(32'd30);
    c = 0;
    while (!(out_valid && out_idx == 6'd20) && c < 200) begin
      accept = 1;
      tick();
      c++;
    end
    accept = 0;
    check("flush_at_beat", 32'(out_idx), 32'd20);
    img_start = 1;
    tick();
    img_start = 0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_space", 32'(blk_space), 32'd1);
    clr_exp();
    exp_blk[16] = 16'd77;
    push(6'd3, 16'd77);
    eob(32'd31);
    drain(32'd31, 0);
    clr_exp();
    eob(32'd40);
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    push(6'd0, 16'd55);
    push(6'd1, 16'd66);
    #3;
    rst_n = 0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_space", 32'(blk_space), 32'd1);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_id", out_id, 32'd0);
    check("arst_last", 32'(out_last), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd0);
    end
    exp_blk[0] = 16'd8;
    push(6'd0, 16'd8);
    eob(32'd41);
    drain(32'd41, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
